// File: rtl/load_edge_register_pkg.sv
`default_nettype none
// ============================================================================
// Package     : load_edge_pkg
// Description : Shared width default and data word type for load_edge_register.
// Revision    : 1.0 - initial release
// ============================================================================
package load_edge_pkg;

  localparam int LOAD_EDGE_WIDTH_DEFAULT = 4;

  typedef logic [LOAD_EDGE_WIDTH_DEFAULT-1:0] load_edge_word_t;

endpackage : load_edge_pkg
`default_nettype wire

// File: rtl/load_edge_register_rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : Registers a strobe and flags its 0->1 transition combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect
  import load_edge_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic prev_d;
  logic prev_q;

  always_comb begin
    prev_d = in;
  end

  // Clearing prev on reset makes a strobe already high at release count as a rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = in & ~prev_q;

endmodule : rise_detect
`default_nettype wire

// File: rtl/load_edge_register.sv
`default_nettype none
// ============================================================================
// Module      : load_edge_register
// Description : Captures data on each rising edge of load and holds it on out;
//               loaded pulses for one cycle alongside each update.
//               Optional macro LOAD_EDGE_SYNC_EN adds 2-flop input synchronizers.
// Revision    : 1.0 - initial release
// ============================================================================
module load_edge_register
  import load_edge_pkg::*;
#(
  parameter int WIDTH = LOAD_EDGE_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  output logic [WIDTH-1:0] out,
  output logic             loaded
);

  logic             load_core;
  logic [WIDTH-1:0] data_core;
  logic             rise;

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             loaded_d;
  logic             loaded_q;

`ifdef LOAD_EDGE_SYNC_EN
  logic             load_s1_d, load_s1_q;
  logic             load_s2_d, load_s2_q;
  logic [WIDTH-1:0] data_s1_d, data_s1_q;
  logic [WIDTH-1:0] data_s2_d, data_s2_q;

  always_comb begin
    load_s1_d = load;
    load_s2_d = load_s1_q;
    data_s1_d = data;
    data_s2_d = data_s1_q;
  end

  // data travels the same two stages as load so the captured word lines up with its strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_s1_q <= 1'b0;
      load_s2_q <= 1'b0;
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      load_s1_q <= load_s1_d;
      load_s2_q <= load_s2_d;
      data_s1_q <= data_s1_d;
      data_s2_q <= data_s2_d;
    end
  end

  assign load_core = load_s2_q;
  assign data_core = data_s2_q;
`else
  assign load_core = load;
  assign data_core = data;
`endif

  rise_detect u_rise_detect (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (load_core),
    .rise  (rise)
  );

  always_comb begin
    out_d    = out_q;
    loaded_d = 1'b0;
    if (rise) begin
      out_d    = data_core;
      loaded_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      loaded_q <= loaded_d;
    end
  end

  assign out    = out_q;
  assign loaded = loaded_q;

endmodule : load_edge_register
`default_nettype wire

// File: tb/tb_load_edge_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_edge_register
// Description : Scoreboard bench for load_edge_register (plain or LOAD_EDGE_SYNC_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_edge_register;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic             loaded;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] data;
  logic             load;
  logic [WIDTH-1:0] out;
  logic             loaded;

  int n_total;
  int n_bad;

  exp_t exp_q[$];

  // Reference model state
  logic             m_prev;
  logic [WIDTH-1:0] m_out;
  logic             m_loaded;
  logic             m_l1, m_l2;
  logic [WIDTH-1:0] m_d1, m_d2;

  load_edge_register #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    .load   (load),
    .out    (out),
    .loaded (loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic             l_eff;
    logic [WIDTH-1:0] d_eff;
    logic             r;
`ifdef LOAD_EDGE_SYNC_EN
    l_eff = m_l2;
    d_eff = m_d2;
`else
    l_eff = load;
    d_eff = data;
`endif
    if (!rst_n) begin
      m_prev = 1'b0; m_out = '0; m_loaded = 1'b0;
      m_l1 = 1'b0; m_l2 = 1'b0; m_d1 = '0; m_d2 = '0;
    end else begin
      r        = l_eff & ~m_prev;
      m_loaded = r;
      if (r) m_out = d_eff;
      m_prev = l_eff;
      m_l2 = m_l1; m_l1 = load;
      m_d2 = m_d1; m_d1 = data;
    end
  endtask

  task automatic step(input string tag, input logic r_n, input logic [WIDTH-1:0] d, input logic ld);
    exp_t e;
    exp_t got;
    rst_n = r_n;
    data  = d;
    load  = ld;
    model_edge();
    e.out    = m_out;
    e.loaded = m_loaded;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check_val({tag, "_out"}, {28'd0, out}, {28'd0, got.out});
      check_val({tag, "_loaded"}, {31'd0, loaded}, {31'd0, got.loaded});
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    m_prev = 1'b0; m_out = '0; m_loaded = 1'b0;
    m_l1 = 1'b0; m_l2 = 1'b0; m_d1 = '0; m_d2 = '0;
    rst_n = 1'b0; data = '0; load = 1'b0;

    // Reset with load high, then release with load still high
    step("rst0", 1'b0, 4'hF, 1'b1);
    step("rst1", 1'b0, 4'hF, 1'b1);
    check_val("rst_out_zero", {28'd0, out}, 32'd0);
    for (int i = 0; i < 4; i++) step("rel", 1'b1, 4'hF, 1'b1);

    // Basic capture and data change while load held
    step("bas0", 1'b1, 4'h4, 1'b0);
    step("bas1", 1'b1, 4'h4, 1'b0);
    step("bas2", 1'b1, 4'h4, 1'b1);
    for (int i = 0; i < 4; i++) step("hold", 1'b1, 4'h0, 1'b1);
`ifndef LOAD_EDGE_SYNC_EN
    check_val("hold_out4", {28'd0, out}, 32'h4);
`endif

    // Re-capture
    step("rc0", 1'b1, 4'h0, 1'b0);
    step("rc1", 1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) step("rc2", 1'b1, 4'h0, 1'b1);
    step("rc3", 1'b1, 4'h5, 1'b0);
    step("rc4", 1'b1, 4'h5, 1'b0);
    for (int i = 0; i < 4; i++) step("rc5", 1'b1, 4'h5, 1'b1);

    // Simultaneous load rise and data change
    step("sim0", 1'b1, 4'h5, 1'b0);
    step("sim1", 1'b1, 4'h5, 1'b0);
    step("sim2", 1'b1, 4'h6, 1'b1);
    for (int i = 0; i < 3; i++) step("sim3", 1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) step("sim4", 1'b1, 4'h0, 1'b1);

    // Equal-value capture still pulses loaded
    step("eq0", 1'b1, 4'h0, 1'b0);
    step("eq1", 1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) step("eq2", 1'b1, 4'h0, 1'b1);

    // Unknown data while no capture must not disturb out
    for (int i = 0; i < 3; i++) step("xd", 1'b1, 'x, 1'b0);
    for (int i = 0; i < 3; i++) step("xd_clr", 1'b1, 4'hA, 1'b0);

    // Reset asserted at the same edge as a load rise
    step("rp0", 1'b1, 4'h9, 1'b0);
    step("rp1", 1'b0, 4'h9, 1'b1);
    check_val("rp_out_zero", {28'd0, out}, 32'd0);
    check_val("rp_loaded_zero", {31'd0, loaded}, 32'd0);
    for (int i = 0; i < 4; i++) step("rp2", 1'b1, 4'h9, 1'b1);

    // Sync-path latency: data=3 rise, out updates exactly 3 edges later
    step("lat0", 1'b1, 4'h3, 1'b0);
    step("lat1", 1'b1, 4'h3, 1'b0);
    step("lat2", 1'b1, 4'h3, 1'b0);
    step("lat3", 1'b1, 4'h3, 1'b1);
    step("lat4", 1'b1, 4'h3, 1'b1);
    step("lat5", 1'b1, 4'h3, 1'b1);
    step("lat6", 1'b1, 4'h3, 1'b1);

    // Random strobes held 1-3 cycles with free-running data
    for (int i = 0; i < 30; i++) begin
      logic             ld;
      int               len;
      ld  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 3);
      for (int j = 0; j < len; j++) step("rnd", 1'b1, 4'($urandom), ld);
    end

    if (exp_q.size() != 0) check_val("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_load_edge_register
`default_nettype wire

// File: doc/load_edge_register.md
Name: load_edge_register

Overview:
- Parameterised holding register; default width 4 bits.
- Captures the `data` bus on each rising edge of the `load` strobe and holds it on `out` until the next rising edge.
- Fully synchronous to one clock; `load` is edge-detected in that clock domain, so a long `load` level causes exactly one capture.
- Sits between a slow control/stimulus source (switches, sequencer) and downstream logic needing a stable latched value.

Parameters:
- WIDTH, 4, bit width of `data` and `out`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- data  input  WIDTH  value to capture.
- load  input  1  load strobe, level signal; capture on its 0->1 transition.
- out  output  WIDTH  currently held value.
- loaded  output  1  one-cycle pulse, high in the cycle after a capture, i.e. coincident with `out` updating.

Behaviour:
- Reset: when rst_n=0 at a clk rising edge:
  - out <= 0, loaded <= 0, load_prev <= 0.
  - Reset has priority over everything, including a simultaneous load edge.
- Edge detect:
  - load_prev <= load every cycle.
  - rise = load & ~load_prev, evaluated combinationally on the sampled `load`.
- Capture:
  - At a clk edge where rise=1: out <= data, using the `data` value sampled at that same edge.
  - loaded <= 1 at that edge.
  - At all other edges: out holds and loaded <= 0.
- Latency: `out` reflects the new value from the first clk edge at which `load` is sampled high after being sampled low, i.e. 1 cycle.
- `load` held high for N cycles produces exactly one capture. Changes to `data` while `load` stays high are ignored.
- `load` falling edge has no effect.
- `load` high at the first edge after reset release counts as a rising edge (load_prev was reset to 0), so it captures.
- Reset asserted mid-hold clears `out` to 0. A capture requires a fresh rise after release, or `load` already high at release per the previous rule.
- Capturing a value equal to the current `out` still pulses `loaded`.
- `load` pulses shorter than one clk period may be missed. This is accepted; the source must hold `load` for at least one clk period high and one low.
- No X propagation from `data` when no capture occurs.

Optional Feature:
- Macro LOAD_EDGE_SYNC_EN.
- Defined:
  - `load` and `data` each pass through a 2-flop synchronizer before edge detection and capture.
  - Synchronizer flops reset to 0.
  - Capture latency becomes 3 cycles from `load` change to `out` update.
  - `data` is captured from its synchronized copy, aligned with the synchronized `load`.
- Undefined: direct 1-cycle path as above; no extra flops.

Decomposition:
- Shared package load_edge_pkg:
  - localparam LOAD_EDGE_WIDTH_DEFAULT = 4.
  - typedef of the WIDTH-bit data word for the default width.
- One sub-module rise_detect (clk, rst_n, in, rise). It holds the prev flop and outputs the combinational rise pulse, and is reusable for other strobes.
- The synchronizer is instantiated inline under the macro, not as a separate module.

Test Plan:
- Reset: rst_n=0 for 2 cycles with data=4'hF and load=1 -> out=0, loaded=0. Release with load still high -> next edge out=4'hF, loaded pulses once.
- Basic capture: data=4 with load low, then load rises -> out=4 after 1 edge, loaded=1 for exactly 1 cycle. Then data=0 while load stays high 2 cycles -> out stays 4.
- Re-capture: load low 2 cycles, data=0, load rises -> out=0. data=5, load low then high for 2 cycles -> out=5 exactly once, single loaded pulse.
- Simultaneous change: load rises and data=6 at the same sample edge -> out=6. Next cycle load=0, data=0 -> out holds 6. Next rise with data=0 -> out=0.
- Reset priority: rst_n=0 at the same edge as a load rise with data=9 -> out=0, loaded=0.
- LOAD_EDGE_SYNC_EN build: data=3, load rises -> out=3 and loaded=1 exactly 3 edges later; unchanged before that.
